sprite_mover: RTL
=================

Name: sprite_mover

Overview:
- Owns one maze sprite's position and motion state.
- Produces the position and direction/bounce flags consumed by the combinational wall-collision checker.
- Consumes the checker's bounce outputs and pushes the sprite back out of walls over several frames.
- Advances once per video frame.

Parameters:
- X_INIT, 20'd320, reset x position in pixels
- Y_INIT, 20'd240, reset y position in pixels
- STEP, 4'd2, pixels moved per frame tick
- BOUNCE_FRAMES, 4'd4, minimum frame ticks spent in BOUNCE
- SPRITE_W, 10'd9, sprite width in pixels, driven on sprite_W
- SPRITE_H, 10'd9, sprite height in pixels, driven on sprite_H

Ports:
- Clk, input, 1, system clock
- Reset_n, input, 1, asynchronous active-low reset
- frame_clk, input, 1, vertical-sync-derived frame strobe, asynchronous to Clk
- key_U, key_D, key_L, key_R, input, 1 each, held direction requests
- bnceU, bnceD, bnceL, bnceR, input, 1 each, bounce requests from the collision checker
- coll_CU, input, 1, OR of the bounce requests (used only for the optional counter)
- sprite_xpos, output, 20, top-left x in pixels
- sprite_ypos, output, 20, top-left y in pixels
- sprite_W, output, 10, constant SPRITE_W
- sprite_H, output, 10, constant SPRITE_H
- U, D, L, R, output, 1 each, one-hot current motion direction, all 0 when not moving
- bcingU, bcingD, bcingL, bcingR, output, 1 each, one-hot direction being bounced off, all 0 outside BOUNCE
- coll_count, output, 16, collision event counter (see Optional Feature)

Behaviour:
- Reset (async, Reset_n=0):
  - xpos=X_INIT, ypos=Y_INIT.
  - U/D/L/R=0, bcing*=0, coll_count=0.
  - State=IDLE, bounce counter=0, synchronizer flops=0.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer plus a rising-edge detect.
  - tick is high for exactly one Clk cycle, on the 3rd Clk edge after frame_clk rises.
  - All state and position updates happen only in the tick cycle; outputs are stable between ticks.
- Key priority when several keys are held: U > D > L > R. No key means no request.
- Bounce sampling:
  - bnce* are combinational from the current registered position and are sampled on the tick cycle.
  - Priority when several are asserted: bnceR > bnceL > bnceD > bnceU.
- IDLE, on tick:
  - Key requested: set the matching direction output, step once, go to MOVE.
  - No key: remain in IDLE.
- MOVE, on tick:
  - Any bnce asserted:
    - Go to BOUNCE.
    - Clear U/D/L/R.
    - Set the bcing flag opposite the bounce (bnceR -> bcingL, bnceL -> bcingR, bnceD -> bcingU, bnceU -> bcingD).
    - Step once in the bounce direction; counter = BOUNCE_FRAMES-1.
  - Otherwise, key requested: set the direction to the key (direction changes allowed), step once.
  - Otherwise: clear the direction and go to IDLE.
- BOUNCE, on tick:
  - Keys are ignored.
  - Step once in the direction opposite the bcing flag.
  - counter>0: decrement the counter.
  - counter==0 and no bnce asserted: clear bcing*, go to IDLE.
  - counter==0 and bnce still asserted: stay in BOUNCE and keep stepping.
- Step arithmetic:
  - Unsigned 20-bit.
  - Left/up: if pos < STEP, result = 0.
  - Right: clamp to 639-SPRITE_W. Down: clamp to 479-SPRITE_H.
  - Clamping does not by itself cause a bounce.
- Invariants: U/D/L/R and bcing* are never simultaneously nonzero; each group is one-hot or zero.
- Reset mid-BOUNCE: immediate return to the reset values; no residual bcing.

Optional Feature:
- SPRITE_MOVER_COLL_CNT_EN defined:
  - coll_count increments, saturating at 16'hFFFF, on each tick where the state is MOVE and coll_CU=1.
  - Entries into BOUNCE only; ticks already in BOUNCE are not counted.
- Not defined: coll_count is tied to 16'd0 and no counter flops are synthesized.

Decomposition:
- Package pokemaze_pkg:
  - Constants: MAP_W=64, MAP_H=48, CELL_PX=10, SCREEN_W=640, SCREEN_H=480.
  - Enum mover_state_t {IDLE, MOVE, BOUNCE}.
  - Enum dir_t {DIR_NONE, DIR_U, DIR_D, DIR_L, DIR_R}.
- Sub-module frame_tick_sync: synchronizer plus edge detect, outputs the 1-cycle tick.

Test Plan:
- Reset with X_INIT=320, Y_INIT=240 -> xpos=320, ypos=240, all flags 0; frame_clk pulse with no keys -> unchanged, IDLE.
- key_R held, 3 frame ticks, no bnce -> R=1, xpos 322, 324, 326 on successive ticks; release key -> next tick R=0, xpos holds.
- key_L at xpos=1, STEP=2 -> xpos=0, then stays 0 on further ticks; no bcing asserted.
- Moving R, bnceL asserted on tick -> R=0, bcingR=1, xpos decreases by 2 per tick for 4 ticks; bnceL low thereafter -> IDLE, bcingR=0.
- bnceR and bnceD both asserted in MOVE -> bnceR wins: bcingL=1, only xpos changes.
- Reset_n low mid-BOUNCE -> outputs at reset values same cycle; with SPRITE_MOVER_COLL_CNT_EN, 3 collisions give coll_count=3, then 0 after reset.

Source files
------------

// File: rtl/pokemaze_pkg.sv
// pokemaze_pkg: shared screen/map constants, sprite state and direction enums.
`default_nettype none

package pokemaze_pkg;

    localparam int MAP_W    = 64;
    localparam int MAP_H    = 48;
    localparam int CELL_PX  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        BOUNCE = 2'd2
    } mover_state_t;

    typedef enum logic [2:0] {
        DIR_NONE = 3'd0,
        DIR_U    = 3'd1,
        DIR_D    = 3'd2,
        DIR_L    = 3'd3,
        DIR_R    = 3'd4
    } dir_t;

    function automatic dir_t dir_opposite(input dir_t d);
        case (d)
            DIR_U:   return DIR_D;
            DIR_D:   return DIR_U;
            DIR_L:   return DIR_R;
            DIR_R:   return DIR_L;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_mover_frame_tick_sync.sv
// frame_tick_sync: brings the async frame strobe into clk and emits a one-cycle tick
// on its rising edge (tick is seen by the 3rd clk edge after frame_clk rises).
`default_nettype none

module frame_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_clk,
    output logic tick
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= frame_clk;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign tick = sync & ~sync_d;

endmodule

`default_nettype wire

// File: rtl/sprite_mover.sv
// sprite_mover: per-frame position/motion FSM for one maze sprite with wall bounce-back.
// Define SPRITE_MOVER_COLL_CNT_EN to build the collision counter on coll_count.
`default_nettype none

module sprite_mover #(
    parameter logic [19:0] X_INIT        = 20'd320,
    parameter logic [19:0] Y_INIT        = 20'd240,
    parameter logic [3:0]  STEP          = 4'd2,
    parameter logic [3:0]  BOUNCE_FRAMES = 4'd4,
    parameter logic [9:0]  SPRITE_W      = 10'd9,
    parameter logic [9:0]  SPRITE_H      = 10'd9
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        key_U,
    input  logic        key_D,
    input  logic        key_L,
    input  logic        key_R,
    input  logic        bnceU,
    input  logic        bnceD,
    input  logic        bnceL,
    input  logic        bnceR,
    input  logic        coll_CU,
    output logic [19:0] sprite_xpos,
    output logic [19:0] sprite_ypos,
    output logic [9:0]  sprite_W,
    output logic [9:0]  sprite_H,
    output logic        U,
    output logic        D,
    output logic        L,
    output logic        R,
    output logic        bcingU,
    output logic        bcingD,
    output logic        bcingL,
    output logic        bcingR,
    output logic [15:0] coll_count
);

    import pokemaze_pkg::*;

    localparam logic [19:0] STEP_W = {16'd0, STEP};
    localparam logic [19:0] X_MAX  = 20'(SCREEN_W - 1) - {10'd0, SPRITE_W};
    localparam logic [19:0] Y_MAX  = 20'(SCREEN_H - 1) - {10'd0, SPRITE_H};

    logic         tick;
    mover_state_t state, state_n;
    dir_t         dir, dir_n;
    dir_t         bdir, bdir_n;
    dir_t         key_dir, bnce_dir, step_dir;
    logic [3:0]   bcnt, bcnt_n;
    logic [19:0]  x_n, y_n;

    frame_tick_sync u_tick (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    function automatic logic [19:0] step_dec(input logic [19:0] pos);
        return (pos < STEP_W) ? 20'd0 : pos - STEP_W;
    endfunction

    function automatic logic [19:0] step_inc(input logic [19:0] pos, input logic [19:0] lim);
        logic [20:0] sum;
        sum = {1'b0, pos} + {1'b0, STEP_W};
        return (sum > {1'b0, lim}) ? lim : sum[19:0];
    endfunction

    always_comb begin
        if (key_U)      key_dir = DIR_U;
        else if (key_D) key_dir = DIR_D;
        else if (key_L) key_dir = DIR_L;
        else if (key_R) key_dir = DIR_R;
        else            key_dir = DIR_NONE;
    end

    // bnce* names the direction to be pushed, so it doubles as the step direction.
    always_comb begin
        if (bnceR)      bnce_dir = DIR_R;
        else if (bnceL) bnce_dir = DIR_L;
        else if (bnceD) bnce_dir = DIR_D;
        else if (bnceU) bnce_dir = DIR_U;
        else            bnce_dir = DIR_NONE;
    end

    always_comb begin
        state_n  = state;
        dir_n    = dir;
        bdir_n   = bdir;
        bcnt_n   = bcnt;
        step_dir = DIR_NONE;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (key_dir != DIR_NONE) begin
                        dir_n    = key_dir;
                        step_dir = key_dir;
                        state_n  = MOVE;
                    end
                end
                MOVE: begin
                    if (bnce_dir != DIR_NONE) begin
                        state_n  = BOUNCE;
                        dir_n    = DIR_NONE;
                        bdir_n   = dir_opposite(bnce_dir);
                        step_dir = bnce_dir;
                        bcnt_n   = BOUNCE_FRAMES - 4'd1;
                    end else if (key_dir != DIR_NONE) begin
                        dir_n    = key_dir;
                        step_dir = key_dir;
                    end else begin
                        dir_n    = DIR_NONE;
                        state_n  = IDLE;
                    end
                end
                BOUNCE: begin
                    step_dir = dir_opposite(bdir);
                    if (bcnt != 4'd0) begin
                        bcnt_n = bcnt - 4'd1;
                    end else if (bnce_dir == DIR_NONE) begin
                        bdir_n  = DIR_NONE;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        x_n = sprite_xpos;
        y_n = sprite_ypos;
        case (step_dir)
            DIR_U:   y_n = step_dec(sprite_ypos);
            DIR_D:   y_n = step_inc(sprite_ypos, Y_MAX);
            DIR_L:   x_n = step_dec(sprite_xpos);
            DIR_R:   x_n = step_inc(sprite_xpos, X_MAX);
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            dir         <= DIR_NONE;
            bdir        <= DIR_NONE;
            bcnt        <= 4'd0;
            sprite_xpos <= X_INIT;
            sprite_ypos <= Y_INIT;
        end else begin
            state       <= state_n;
            dir         <= dir_n;
            bdir        <= bdir_n;
            bcnt        <= bcnt_n;
            sprite_xpos <= x_n;
            sprite_ypos <= y_n;
        end
    end

`ifdef SPRITE_MOVER_COLL_CNT_EN
    // Only MOVE ticks count, so each bounce entry is one event.
    logic [15:0] coll_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            coll_cnt <= 16'd0;
        end else if (tick && state == MOVE && coll_CU && coll_cnt != 16'hFFFF) begin
            coll_cnt <= coll_cnt + 16'd1;
        end
    end

    assign coll_count = coll_cnt;
`else
    logic unused_coll;
    assign unused_coll = coll_CU;
    assign coll_count  = 16'd0;
`endif

    assign sprite_W = SPRITE_W;
    assign sprite_H = SPRITE_H;

    assign U = (dir == DIR_U);
    assign D = (dir == DIR_D);
    assign L = (dir == DIR_L);
    assign R = (dir == DIR_R);

    assign bcingU = (bdir == DIR_U);
    assign bcingD = (bdir == DIR_D);
    assign bcingL = (bdir == DIR_L);
    assign bcingR = (bdir == DIR_R);

endmodule

`default_nettype wire
